ps2_key_decoder: RTL
====================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000, meaning iCLK cycles a prefix state may wait for its next byte before it is abandoned.
REQ-002 SHALL have port iCLK  input  1  meaning the single clock; all state changes on the rising edge.
REQ-003 SHALL have port iRST  input  1  meaning the reset, asynchronous and active-high.
REQ-004 SHALL have port iBYTE_VALID  input  1  meaning a one-cycle strobe that a new PS/2 set-2 byte is present on iBYTE.
REQ-005 SHALL have port iBYTE  input  8  meaning the received scancode byte, sampled only when iBYTE_VALID=1.
REQ-006 SHALL have port oKEY_VALID  output  1  meaning a one-cycle strobe for a new, non-repeated key press.
REQ-007 SHALL have port oKEY_CODE  output  4  meaning the decoded key: 0x0-0x9 digits, 0xA +, 0xB -, 0xC *, 0xD /, 0xE Enter.
REQ-008 SHALL have port oKEY_HELD  output  1  meaning a recognised key is currently held (its make is seen, its break is not).

Function
REQ-009 SHALL implement FSM states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 F0 seen).
REQ-010 SHALL move on iBYTE=E0 from any state to EXT.
REQ-011 SHALL move on iBYTE=F0 from IDLE to BRK and from EXT to EXT_BRK; in BRK or EXT_BRK an F0 SHALL leave the state unchanged.
REQ-012 SHALL treat any other byte as a terminal byte, decode it with the extended flag (state EXT or EXT_BRK), and return to IDLE.
REQ-013 SHALL decode a non-extended terminal byte as follows: 70->0, 69->1, 72->2, 7A->3, 6B->4, 73->5, 74->6, 6C->7, 75->8, 7D->9, 79->A, 7B->B, 7C->C, 4A->D, 5A->E.
REQ-014 SHALL decode an extended terminal byte only for 4A->D and 5A->E; every other extended byte, and every unlisted byte, is unrecognised.
REQ-015 SHALL, for an unrecognised terminal byte, return to IDLE with no strobe and no change to the held register.
REQ-016 SHALL, for a recognised make (from IDLE or EXT), pulse oKEY_VALID and update oKEY_CODE in the cycle after the iBYTE_VALID cycle (latency 1), unless the key matches the held key.
REQ-017 SHALL hold oKEY_CODE stable until the next oKEY_VALID.
REQ-018 SHALL keep a held register of {code, ext flag, valid}; a recognised make loads it and sets oKEY_HELD=1.
REQ-019 SHALL suppress a make whose code and ext flag equal the held register while oKEY_HELD=1 (typematic repeat): no strobe.
REQ-020 SHALL clear oKEY_HELD on a recognised break (from BRK or EXT_BRK) that matches the held register; a non-matching break SHALL have no effect.
REQ-021 SHALL make a new different-key make while another key is held emit a strobe and replace the held register.
REQ-022 SHALL use a timeout counter that reloads to TIMEOUT_CYC-1 on every accepted byte and decrements in any non-IDLE state; reaching 0 in a non-IDLE state SHALL force IDLE with no strobe.
REQ-023 SHALL give iBYTE_VALID priority over timeout expiry in the same cycle: the byte is processed in the current state.
REQ-024 SHALL leave the outputs unaffected by iBYTE when iBYTE_VALID=0.

Reset
REQ-025 SHALL, while iRST=1, immediately force state IDLE, oKEY_VALID=0, oKEY_CODE=0x0, oKEY_HELD=0, held register cleared, and timeout counter=0.
REQ-026 SHALL discard a partial sequence interrupted by reset (e.g. E0 followed by reset, then 5A): 5A decodes as non-extended Enter.
REQ-027 SHALL produce its first strobe no earlier than the first iBYTE_VALID after iRST deasserts.

Verification
REQ-028 SHALL be verified with: bytes 69, F0, 69 -> one oKEY_VALID with code 0x1; oKEY_HELD goes 1, then 0 after the break.
REQ-029 SHALL be verified with: bytes 73, 73, 73, F0, 73, 73 -> exactly two strobes, both code 0x5.
REQ-030 SHALL be verified with: bytes E0, 5A, E0, F0, 5A -> one strobe with code 0xE and held cleared; separately, E0 70 -> no strobe.
REQ-031 SHALL be verified with: bytes 72 then 7A without a break -> strobes 0x2 then 0x3; then F0 72 -> oKEY_HELD stays 1.
REQ-032 SHALL be verified with TIMEOUT_CYC=8: byte F0, 8 idle cycles, then 6B -> state back in IDLE and a strobe with code 0x4 (a make, not a break).
REQ-033 SHALL be verified with: iRST pulsed mid-sequence after E0 -> all outputs 0 within the same cycle; subsequent 4A -> code 0xD.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder for a numeric keypad: tracks E0/F0 prefixes,
// emits one strobe per new key press and suppresses typematic repeats.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iBYTE_VALID,
    input  logic [7:0] iBYTE,
    output logic       oKEY_VALID,
    output logic [3:0] oKEY_CODE,
    output logic       oKEY_HELD
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic [3:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic             held_vld_q, held_vld_d;

    // Returns {recognised, code}; only the keypad / and Enter exist as extended keys.
    function automatic logic [4:0] decode(input logic [7:0] b, input logic ext);
        logic [4:0] r;
        r = 5'b0_0000;
        if (ext) begin
            case (b)
                8'h4A:   r = 5'h1D;
                8'h5A:   r = 5'h1E;
                default: r = 5'b0_0000;
            endcase
        end else begin
            case (b)
                8'h70:   r = 5'h10;
                8'h69:   r = 5'h11;
                8'h72:   r = 5'h12;
                8'h7A:   r = 5'h13;
                8'h6B:   r = 5'h14;
                8'h73:   r = 5'h15;
                8'h74:   r = 5'h16;
                8'h6C:   r = 5'h17;
                8'h75:   r = 5'h18;
                8'h7D:   r = 5'h19;
                8'h79:   r = 5'h1A;
                8'h7B:   r = 5'h1B;
                8'h7C:   r = 5'h1C;
                8'h4A:   r = 5'h1D;
                8'h5A:   r = 5'h1E;
                default: r = 5'b0_0000;
            endcase
        end
        return r;
    endfunction

    logic       is_ext;
    logic       is_brk;
    logic [4:0] dec;
    logic       same_as_held;

    always_comb begin
        is_ext       = (state_q == EXT) || (state_q == EXT_BRK);
        is_brk       = (state_q == BRK) || (state_q == EXT_BRK);
        dec          = decode(iBYTE, is_ext);
        same_as_held = held_vld_q && (held_code_q == dec[3:0]) && (held_ext_q == is_ext);

        state_d     = state_q;
        cnt_d       = cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        held_code_d = held_code_q;
        held_ext_d  = held_ext_q;
        held_vld_d  = held_vld_q;

        // A byte arriving in the same cycle as expiry wins and is taken in the current state.
        if (iBYTE_VALID) begin
            cnt_d = RELOAD;
            if (iBYTE == 8'hE0) begin
                state_d = EXT;
            end else if (iBYTE == 8'hF0) begin
                if (state_q == IDLE)     state_d = BRK;
                else if (state_q == EXT) state_d = EXT_BRK;
            end else begin
                state_d = IDLE;
                if (dec[4]) begin
                    if (is_brk) begin
                        if (same_as_held) held_vld_d = 1'b0;
                    end else if (!same_as_held) begin
                        key_valid_d = 1'b1;
                        key_code_d  = dec[3:0];
                        held_code_d = dec[3:0];
                        held_ext_d  = is_ext;
                        held_vld_d  = 1'b1;
                    end
                end
            end
        end else if (state_q != IDLE) begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            held_code_q <= 4'h0;
            held_ext_q  <= 1'b0;
            held_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            held_code_q <= held_code_d;
            held_ext_q  <= held_ext_d;
            held_vld_q  <= held_vld_d;
        end
    end

    assign oKEY_VALID = key_valid_q;
    assign oKEY_CODE  = key_code_q;
    assign oKEY_HELD  = held_vld_q;

endmodule
